// File: rtl/boot_rom_copier.sv
//============================================================================
// boot_rom_copier : copies NWORDS words from boot ROM to on-chip RAM after
//                   reset and holds the CPU in reset until the copy is done.
// Optional macro  : BOOT_COPY_CSUM_EN (running 32-bit sum of words read)
// Revision        : 1.0
//============================================================================
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE  3'b000
`endif
`ifndef OCP_CMD_WRITE
`define OCP_CMD_WRITE 3'b001
`endif
`ifndef OCP_CMD_READ
`define OCP_CMD_READ  3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif
`ifndef OCP_RESP_DVA
`define OCP_RESP_DVA  2'b01
`endif
`ifndef OCP_RESP_FAIL
`define OCP_RESP_FAIL 2'b10
`endif
`ifndef OCP_RESP_ERR
`define OCP_RESP_ERR  2'b11
`endif

module boot_rom_copier #(
  parameter logic [31:0] SRC_BASE  = 32'h0000_0000,
  parameter logic [31:0] DST_BASE  = 32'h1000_0000,
  parameter int unsigned NWORDS    = 1024,
  parameter bit          AUTOSTART = 1'b1
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_start,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic                   o_cpu_nrst,
  output logic [31:0]            o_csum,
  output logic [`ADDR_WIDTH-1:0] o_rd_MAddr,
  output logic [2:0]             o_rd_MCmd,
  input  logic                   i_rd_SCmdAccept,
  input  logic [`DATA_WIDTH-1:0] i_rd_SData,
  input  logic [1:0]             i_rd_SResp,
  output logic [`ADDR_WIDTH-1:0] o_wr_MAddr,
  output logic [2:0]             o_wr_MCmd,
  output logic [`DATA_WIDTH-1:0] o_wr_MData,
  output logic [`BEN_WIDTH-1:0]  o_wr_MByteEn,
  input  logic                   i_wr_SCmdAccept,
  input  logic [1:0]             i_wr_SResp
);

  localparam int unsigned AW = `ADDR_WIDTH;
  localparam int unsigned DW = `DATA_WIDTH;
  localparam int unsigned CW = (NWORDS == 0) ? 1 : $clog2(NWORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(NWORDS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          auto_q, auto_d;
  logic          cpu_rel_q, cpu_rel_d;
  logic          go;
  logic [AW-1:0] src_addr, dst_addr;
`ifdef BOOT_COPY_CSUM_EN
  logic [31:0]   csum_q, csum_d;
`endif

  assign src_addr = SRC_BASE[AW-1:0] + (AW'(cnt_q) << 2);
  assign dst_addr = DST_BASE[AW-1:0] + (AW'(cnt_q) << 2);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    auto_d    = auto_q;
    cpu_rel_d = cpu_rel_q;
    go        = 1'b0;
`ifdef BOOT_COPY_CSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      S_IDLE:          go = i_start | auto_q;
      S_DONE, S_ERROR: go = i_start;
      S_RD_REQ:  if (i_rd_SCmdAccept) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        case (i_rd_SResp)
          `OCP_RESP_DVA: begin
            wdata_d = i_rd_SData;
            state_d = S_WR_REQ;
`ifdef BOOT_COPY_CSUM_EN
            csum_d  = csum_q + i_rd_SData[31:0];
`endif
          end
          `OCP_RESP_FAIL, `OCP_RESP_ERR: state_d = S_ERROR;
          default: ;
        endcase
      end
      S_WR_REQ:  if (i_wr_SCmdAccept) state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        case (i_wr_SResp)
          `OCP_RESP_DVA: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q + CW'(1) == LAST) begin
              state_d   = S_DONE;
              cpu_rel_d = 1'b1;
            end else begin
              state_d   = S_RD_REQ;
            end
          end
          `OCP_RESP_FAIL, `OCP_RESP_ERR: state_d = S_ERROR;
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    // Start is only honoured from the three non-busy states.
    if (go) begin
      auto_d = 1'b0;
      cnt_d  = '0;
`ifdef BOOT_COPY_CSUM_EN
      csum_d = '0;
`endif
      if (NWORDS == 0) begin
        state_d   = S_DONE;
        cpu_rel_d = 1'b1;
      end else begin
        state_d   = S_RD_REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wdata_q   <= '0;
      auto_q    <= AUTOSTART;
      cpu_rel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wdata_q   <= wdata_d;
      auto_q    <= auto_d;
      cpu_rel_q <= cpu_rel_d;
    end
  end

`ifdef BOOT_COPY_CSUM_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) csum_q <= '0;
    else       csum_q <= csum_d;
  end
  assign o_csum = csum_q;
`else
  assign o_csum = '0;
`endif

  assign o_busy     = state_q inside {S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT};
  assign o_done     = (state_q == S_DONE);
  assign o_err      = (state_q == S_ERROR);
  assign o_cpu_nrst = cpu_rel_q;

  assign o_rd_MCmd    = (state_q == S_RD_REQ) ? `OCP_CMD_READ : `OCP_CMD_IDLE;
  assign o_rd_MAddr   = (state_q == S_RD_REQ) ? src_addr : '0;
  assign o_wr_MCmd    = (state_q == S_WR_REQ) ? `OCP_CMD_WRITE : `OCP_CMD_IDLE;
  assign o_wr_MAddr   = (state_q == S_WR_REQ) ? dst_addr : '0;
  assign o_wr_MData   = (state_q == S_WR_REQ) ? wdata_q : '0;
  assign o_wr_MByteEn = (state_q == S_WR_REQ) ? '1 : '0;

endmodule

`default_nettype wire

// File: tb/tb_boot_rom_copier.sv
//============================================================================
// tb_boot_rom_copier : three copier instances (autostart/4 words,
//                      manual/4 words, manual/0 words) against OCP slave models.
// Revision           : 1.0
//============================================================================
`default_nettype none

module tb_boot_rom_copier;

  localparam logic [2:0]  CMD_IDLE  = 3'b000;
  localparam logic [2:0]  CMD_WRITE = 3'b001;
  localparam logic [2:0]  CMD_READ  = 3'b010;
  localparam logic [1:0]  RESP_NULL = 2'b00;
  localparam logic [1:0]  RESP_DVA  = 2'b01;
  localparam logic [1:0]  RESP_ERR  = 2'b11;
  localparam logic [31:0] SRC       = 32'h0000_0000;
  localparam logic [31:0] DST       = 32'h1000_0000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst    [3];
  logic        start   [3];
  logic        busy    [3];
  logic        done    [3];
  logic        err     [3];
  logic        cpu     [3];
  logic [31:0] csum    [3];
  logic [31:0] rd_addr [3];
  logic [2:0]  rd_cmd  [3];
  logic        rd_acc  [3];
  logic [31:0] rd_data [3];
  logic [1:0]  rd_resp [3];
  logic [31:0] wr_addr [3];
  logic [2:0]  wr_cmd  [3];
  logic [31:0] wr_data [3];
  logic [3:0]  wr_ben  [3];
  logic        wr_acc  [3];
  logic [1:0]  wr_resp [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    boot_rom_copier #(
      .SRC_BASE (SRC),
      .DST_BASE (DST),
      .NWORDS   ((g == 2) ? 0 : 4),
      .AUTOSTART(g == 0)
    ) u_dut (
      .clk            (clk),
      .nrst           (nrst[g]),
      .i_start        (start[g]),
      .o_busy         (busy[g]),
      .o_done         (done[g]),
      .o_err          (err[g]),
      .o_cpu_nrst     (cpu[g]),
      .o_csum         (csum[g]),
      .o_rd_MAddr     (rd_addr[g]),
      .o_rd_MCmd      (rd_cmd[g]),
      .i_rd_SCmdAccept(rd_acc[g]),
      .i_rd_SData     (rd_data[g]),
      .i_rd_SResp     (rd_resp[g]),
      .o_wr_MAddr     (wr_addr[g]),
      .o_wr_MCmd      (wr_cmd[g]),
      .o_wr_MData     (wr_data[g]),
      .o_wr_MByteEn   (wr_ben[g]),
      .i_wr_SCmdAccept(wr_acc[g]),
      .i_wr_SResp     (wr_resp[g])
    );
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ROM image: word i holds (i+1) repeated in every nibble.
  function automatic logic [31:0] img(input int i);
    return 32'h1111_1111 * 32'(i + 1);
  endfunction

  // Slave/model state owned by the bfm process; main process only sets plans.
  int          stall_word [3] = '{default: 0};
  int          stall_n    [3] = '{default: 0};
  int          err_word   [3] = '{default: -1};
  int          stall_used [3] = '{default: 0};
  int          rd_pend    [3] = '{default: -1};
  bit          wr_pend    [3] = '{default: 0};
  int          exp_rd     [3] = '{default: 0};
  int          exp_wr     [3] = '{default: 0};
  int          rd_cnt     [3] = '{default: 0};
  int          wr_cnt     [3] = '{default: 0};
  int          issued     [3] = '{default: 0};
  bit          cpu_seen   [3] = '{default: 0};
  bit          p_rpend    [3] = '{default: 0};
  bit          p_wpend    [3] = '{default: 0};
  logic [34:0] p_rd       [3];
  logic [70:0] p_wr       [3];
  logic [31:0] ram        [3][4];

  initial begin
    for (int k = 0; k < 3; k++) begin
      rd_acc[k] = 1'b1; wr_acc[k] = 1'b1;
      rd_resp[k] = RESP_NULL; wr_resp[k] = RESP_NULL; rd_data[k] = '0;
      for (int i = 0; i < 4; i++) ram[k][i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!nrst[k]) begin
          exp_rd[k] = 0; exp_wr[k] = 0; cpu_seen[k] = 0;
          p_rpend[k] = 0; p_wpend[k] = 0;
        end else begin
          if (start[k] && !busy[k]) begin
            exp_rd[k] = 0; exp_wr[k] = 0; rd_cnt[k] = 0; wr_cnt[k] = 0; stall_used[k] = 0;
          end
          if (p_rpend[k]) chk("rd_hold", {rd_cmd[k], rd_addr[k]}, p_rd[k]);
          if (p_wpend[k]) chk("wr_hold", {wr_cmd[k], wr_addr[k], wr_data[k], wr_ben[k]}, p_wr[k]);
          if (rd_cmd[k] != CMD_IDLE || wr_cmd[k] != CMD_IDLE) issued[k]++;
          if (rd_cmd[k] == CMD_READ && rd_acc[k]) begin
            chk("rd_addr", rd_addr[k], SRC + 32'(4 * exp_rd[k]));
            rd_pend[k] = int'((rd_addr[k] - SRC) >> 2);
            exp_rd[k]++; rd_cnt[k]++;
          end
          if (wr_cmd[k] == CMD_WRITE && wr_acc[k]) begin
            chk("wr_addr", wr_addr[k], DST + 32'(4 * exp_wr[k]));
            chk("wr_data", wr_data[k], img(exp_wr[k]));
            chk("wr_ben", wr_ben[k], 4'hF);
            ram[k][((wr_addr[k] - DST) >> 2) & 32'd3] = wr_data[k];
            wr_pend[k] = 1'b1;
            exp_wr[k]++; wr_cnt[k]++;
          end
          chk("busy_done_excl", busy[k] & done[k], 1'b0);
          if (cpu_seen[k]) chk("cpu_sticky", cpu[k], 1'b1);
          cpu_seen[k] = cpu_seen[k] | cpu[k];
          p_rpend[k] = (rd_cmd[k] != CMD_IDLE) && !rd_acc[k];
          p_wpend[k] = (wr_cmd[k] != CMD_IDLE) && !wr_acc[k];
          p_rd[k]    = {rd_cmd[k], rd_addr[k]};
          p_wr[k]    = {wr_cmd[k], wr_addr[k], wr_data[k], wr_ben[k]};
        end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (rd_pend[k] >= 0) begin
          rd_resp[k] = (rd_pend[k] == err_word[k]) ? RESP_ERR : RESP_DVA;
          rd_data[k] = img(rd_pend[k]);
          rd_pend[k] = -1;
        end else begin
          rd_resp[k] = RESP_NULL;
          rd_data[k] = 32'hDEAD_BEEF;
        end
        wr_resp[k] = wr_pend[k] ? RESP_DVA : RESP_NULL;
        wr_pend[k] = 1'b0;
        if (wr_cmd[k] == CMD_WRITE && wr_addr[k] == DST + 32'(4 * stall_word[k]) &&
            stall_used[k] < stall_n[k]) begin
          wr_acc[k] = 1'b0;
          stall_used[k]++;
        end else begin
          wr_acc[k] = 1'b1;
        end
      end
    end
  end

  // Cycle 1 is the first edge after the call; returns the cycle o_done or o_err is seen.
  task automatic run_copy(input int k, input bit do_start, input int restart_at,
                          input int bound, output int cyc);
    cyc = -1;
    if (do_start) start[k] = 1'b1;
    for (int c = 1; c <= bound; c++) begin
      @(posedge clk); #2;
      start[k] = (c == restart_at);
      if (done[k] || err[k]) begin
        cyc = c;
        break;
      end
    end
    start[k] = 1'b0;
  endtask

  task automatic check_idle(input int k, input string tag);
    chk({tag, "_rd_cmd"},  rd_cmd[k],  CMD_IDLE);
    chk({tag, "_rd_addr"}, rd_addr[k], 32'h0);
    chk({tag, "_wr_cmd"},  wr_cmd[k],  CMD_IDLE);
    chk({tag, "_wr_addr"}, wr_addr[k], 32'h0);
    chk({tag, "_wr_data"}, wr_data[k], 32'h0);
    chk({tag, "_wr_ben"},  wr_ben[k],  4'h0);
    chk({tag, "_busy"},    busy[k],    1'b0);
    chk({tag, "_done"},    done[k],    1'b0);
    chk({tag, "_err"},     err[k],     1'b0);
    chk({tag, "_cpu"},     cpu[k],     1'b0);
    chk({tag, "_csum"},    csum[k],    32'h0);
  endtask

  initial begin
    int cyc;
    int snap;
    bit found;
    for (int k = 0; k < 3; k++) begin nrst[k] = 1'b1; start[k] = 1'b0; end
    #1;
    for (int k = 0; k < 3; k++) nrst[k] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) check_idle(k, "reset");

    // Autostart copy of four words, ideal slaves.
    for (int k = 0; k < 3; k++) nrst[k] = 1'b1;
    run_copy(0, 1'b0, 0, 100, cyc);
    chk("auto_done_cycle", cyc, 17);
    chk("auto_cpu", cpu[0], 1'b1);
    chk("auto_busy", busy[0], 1'b0);
    chk("auto_err", err[0], 1'b0);
    chk("auto_writes", wr_cnt[0], 4);
    chk("auto_ram0", ram[0][0], 32'h1111_1111);
    chk("auto_ram1", ram[0][1], 32'h2222_2222);
    chk("auto_ram2", ram[0][2], 32'h3333_3333);
    chk("auto_ram3", ram[0][3], 32'h4444_4444);
`ifdef BOOT_COPY_CSUM_EN
    chk("auto_csum", csum[0], 32'hAAAA_AAAA);
`else
    chk("auto_csum", csum[0], 32'h0);
`endif
    chk("manual_no_autostart", issued[1], 0);
    chk("zero_no_autostart", issued[2], 0);

    // RAM withholds accept for three cycles on word 1.
    stall_word[0] = 1; stall_n[0] = 3;
    run_copy(0, 1'b1, 0, 100, cyc);
    chk("stall_done_cycle", cyc, 20);
    chk("stall_writes", wr_cnt[0], 4);
    chk("stall_cpu", cpu[0], 1'b1);
    stall_n[0] = 0;

    // ROM returns ERR on word 2, then a restart recovers.
    err_word[1] = 2;
    run_copy(1, 1'b1, 0, 100, cyc);
    chk("err_cycle", cyc, 11);
    chk("err_flag", err[1], 1'b1);
    chk("err_busy", busy[1], 1'b0);
    chk("err_done", done[1], 1'b0);
    chk("err_cpu", cpu[1], 1'b0);
    chk("err_writes", wr_cnt[1], 2);
    chk("err_reads", rd_cnt[1], 3);
    err_word[1] = -1;
    run_copy(1, 1'b1, 0, 100, cyc);
    chk("recover_cycle", cyc, 17);
    chk("recover_done", done[1], 1'b1);
    chk("recover_err", err[1], 1'b0);
    chk("recover_cpu", cpu[1], 1'b1);
    chk("recover_writes", wr_cnt[1], 4);

    // Start pulse while busy is ignored.
    run_copy(1, 1'b1, 5, 100, cyc);
    chk("busy_start_cycle", cyc, 17);
    chk("busy_start_writes", wr_cnt[1], 4);
    chk("busy_start_reads", rd_cnt[1], 4);

    // Zero-length copy.
    run_copy(2, 1'b1, 0, 10, cyc);
    chk("zero_done_cycle", cyc, 1);
    chk("zero_done", done[2], 1'b1);
    chk("zero_cpu", cpu[2], 1'b1);
    chk("zero_busy", busy[2], 1'b0);
    chk("zero_no_cmd", issued[2], 0);

    // Reset during WR_WAIT of word 3.
    found = 1'b0;
    start[1] = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #2;
      start[1] = 1'b0;
      if (wr_cnt[1] == 4) begin found = 1'b1; break; end
    end
    start[1] = 1'b0;
    chk("midreset_reached", found, 1'b1);
    nrst[1] = 1'b0;
    #1;
    check_idle(1, "midreset");
    snap = issued[1];
    repeat (2) @(posedge clk);
    #2;
    nrst[1] = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check_idle(1, "postreset");
    chk("postreset_no_cmd", issued[1], snap);
    run_copy(1, 1'b1, 0, 100, cyc);
    chk("postreset_cycle", cyc, 17);
    chk("postreset_cpu", cpu[1], 1'b1);
    chk("postreset_writes", wr_cnt[1], 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/boot_rom_copier.md
Name: boot_rom_copier

Overview:
- OCP master that sits directly upstream of the boot ROM and copies a fixed image from ROM to on-chip RAM after reset.
- Holds the CPU in reset until the copy completes, then releases it.
- Has two single-outstanding OCP master ports, one facing the ROM and one facing the RAM.
- Uses the codebase's `ADDR_WIDTH`, `DATA_WIDTH` and `BEN_WIDTH` defines and the OCP_CMD_* / OCP_RESP_* constants.

Parameters:
- SRC_BASE, 32'h0000_0000: ROM byte address of the first word; word-aligned.
- DST_BASE, 32'h1000_0000: RAM byte address of the first word; word-aligned.
- NWORDS, 1024: number of 32-bit words to copy; 0 is legal.
- AUTOSTART, 1: 1 = start copying automatically on the first cycle after reset release; 0 = wait for i_start.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous, active-low reset
- i_start  in  1  single-cycle start pulse; ignored while busy
- o_busy  out  1  copy in progress
- o_done  out  1  sticky; copy finished without error
- o_err  out  1  sticky; an FAIL or ERR response was received
- o_cpu_nrst  out  1  CPU reset; low until o_done
- o_csum  out  32  running checksum (see Optional Feature)
- o_rd_MAddr  out  `ADDR_WIDTH  ROM-side address
- o_rd_MCmd  out  3  ROM-side command
- i_rd_SCmdAccept  in  1  ROM-side command accept
- i_rd_SData  in  `DATA_WIDTH  ROM-side read data
- i_rd_SResp  in  2  ROM-side response
- o_wr_MAddr  out  `ADDR_WIDTH  RAM-side address
- o_wr_MCmd  out  3  RAM-side command
- o_wr_MData  out  `DATA_WIDTH  RAM-side write data
- o_wr_MByteEn  out  `BEN_WIDTH  RAM-side byte enables
- i_wr_SCmdAccept  in  1  RAM-side command accept
- i_wr_SResp  in  2  RAM-side response

Behaviour:
- Reset, while nrst is low, all outputs take these values:
  - MCmd = OCP_CMD_IDLE; MAddr, MData, o_csum = 0; MByteEn = 0.
  - o_busy, o_done, o_err = 0; o_cpu_nrst = 0.
  - FSM = IDLE; word counter = 0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, ERROR.
- IDLE:
  - Starts on i_start, or on the first cycle after reset when AUTOSTART=1.
  - On start: clear o_done, o_err and o_csum; set counter = 0; set o_busy = 1.
  - If NWORDS=0, go directly to DONE; otherwise go to RD_REQ.
- RD_REQ:
  - Drive o_rd_MCmd = READ and o_rd_MAddr = SRC_BASE + 4*counter.
  - Hold both stable until i_rd_SCmdAccept = 1.
  - In the accept cycle, register the command; MCmd returns to IDLE on the next edge; go to RD_WAIT.
- RD_WAIT:
  - Sample i_rd_SResp every cycle; NULL means keep waiting with no limit.
  - DVA: latch i_rd_SData into the write-data register and go to WR_REQ.
  - FAIL or ERR: go to ERROR.
- WR_REQ:
  - Drive o_wr_MCmd = WRITE, o_wr_MAddr = DST_BASE + 4*counter, o_wr_MData = latched word, o_wr_MByteEn = all ones.
  - Hold until i_wr_SCmdAccept = 1, then go to WR_WAIT.
- WR_WAIT:
  - DVA: increment the counter. If counter+1 == NWORDS go to DONE, else go to RD_REQ.
  - FAIL or ERR: go to ERROR.
- Response sampling rule: SResp is only sampled in the WAIT states. A response seen in a REQ state is ignored.
- Throughput: with 1-cycle-latency always-accepting slaves, each word takes 4 cycles.
  - A copy of N words finishes with o_done rising exactly 4N+1 cycles after start (IDLE exit cycle included).
- DONE: o_busy = 0, o_done = 1, o_cpu_nrst = 1. o_cpu_nrst stays high until nrst. A new i_start re-runs the copy without lowering o_cpu_nrst.
- ERROR: o_busy = 0, o_err = 1, o_cpu_nrst stays 0. Only nrst or i_start leaves this state; i_start re-runs from word 0.
- i_start while o_busy = 1: ignored.
- Address arithmetic: modulo 2^`ADDR_WIDTH, wrapping silently. The counter is wide enough for NWORDS (clog2(NWORDS+1) bits, minimum 1).
- Reset mid-copy: abort immediately. Any outstanding response arriving after reset release is ignored, because the FSM is in IDLE and no WAIT state is active.

Optional Feature:
- Macro: BOOT_COPY_CSUM_EN.
- Defined: on each accepted RD_WAIT DVA, o_csum <= o_csum + i_rd_SData (32-bit, wraps). The final value is valid when o_done = 1.
- Undefined: o_csum is constant 0 and no adder is synthesized.

Test Plan:
- AUTOSTART=1, NWORDS=4, ROM words 11111111/22222222/33333333/44444444, ideal slaves:
  - RAM[DST_BASE..+12] receives the same values with MByteEn=4'hF.
  - o_done rises at cycle 17 after reset release; o_cpu_nrst rises with it; o_csum = AAAAAAAA when the macro is defined.
- RAM slave deasserts SCmdAccept for 3 cycles on word 1: MAddr, MData and MCmd held stable throughout, no duplicate write, total time 20 cycles.
- ROM returns ERR on word 2: o_err=1, o_busy=0, o_cpu_nrst stays 0, no write issued for word 2. A following i_start recovers and completes.
- NWORDS=0, AUTOSTART=0, i_start pulse: o_done=1 on the next cycle, and neither port ever issues a command.
- nrst asserted during WR_WAIT of word 3, then released with AUTOSTART=0: all outputs at reset values and no command issued until i_start.
- i_start pulsed while busy: no restart, counter unaffected, copy completes normally.
